hall_call_dispatcher: RTL

//  Two-car hall-call scheduler for the elevator system. Latches external (hall) button pulses
//  and assigns each call to exactly one car by a distance/direction cost. Holds each call until
//  the owning car stops at that floor. Drives per-car call vectors into two elevator_controller

---
 rtl/hall_call_dispatcher_pkg.sv | 23 ++
 rtl/hall_call_dispatcher_if.sv | 26 ++
 rtl/hall_call_dispatcher_onehot_to_idx.sv | 17 +
 rtl/hall_call_dispatcher.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/hall_call_dispatcher_pkg.sv
// Shared constants for the hall-call dispatcher: car state encoding, FSM states, width helpers.
package hall_call_dispatcher_pkg;

    localparam int unsigned N_FLOORS_DEF = 5;

    // car state is {move, direction}
    localparam logic MV_IDLE   = 1'b0;
    localparam logic MV_MOVING = 1'b1;
    localparam logic DIR_UP    = 1'b1;
    localparam logic DIR_DOWN  = 1'b0;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_COMMIT = 1'b1;

    function automatic int unsigned cost_width(input int unsigned n);
        return $clog2(2 * n) + 1;
    endfunction

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/hall_call_dispatcher_if.sv
// Hall-call dispatcher bus: hall buttons and car status in, per-car call vectors and lamps out.
interface hall_call_dispatcher_if
    import hall_call_dispatcher_pkg::*;
#(
    parameter int unsigned N_FLOORS = N_FLOORS_DEF
);
    logic [N_FLOORS-1:0] external_buttons;
    logic [N_FLOORS-1:0] car0_floor;
    logic [1:0]          car0_state;
    logic [N_FLOORS-1:0] car1_floor;
    logic [1:0]          car1_state;
    logic [N_FLOORS-1:0] car0_calls;
    logic [N_FLOORS-1:0] car1_calls;
    logic [N_FLOORS-1:0] hall_lamp;
    logic                dispatch_busy;

    modport master (
        output external_buttons, car0_floor, car0_state, car1_floor, car1_state,
        input  car0_calls, car1_calls, hall_lamp, dispatch_busy
    );

    modport slave (
        input  external_buttons, car0_floor, car0_state, car1_floor, car1_state,
        output car0_calls, car1_calls, hall_lamp, dispatch_busy
    );
endinterface

// File: rtl/hall_call_dispatcher_onehot_to_idx.sv
// One-hot floor vector to binary index; lowest set bit wins, all-zero maps to floor 0.
module onehot_to_idx
    import hall_call_dispatcher_pkg::*;
#(
    parameter int unsigned N  = N_FLOORS_DEF,
    parameter int unsigned IW = idx_width(N)
) (
    input  logic [N-1:0]  onehot,
    output logic [IW-1:0] idx
);
    always_comb begin
        idx = '0;
        for (int unsigned i = N; i > 0; i--) begin
            if (onehot[i-1]) idx = IW'(i - 1);
        end
    end
endmodule

// File: rtl/hall_call_dispatcher.sv
// Two-car hall-call dispatcher: latches hall presses and assigns each to one car by cost.
// Optional feature macro CALL_TIMEOUT_EN: reassign calls that wait TIMEOUT_CYC cycles.
module hall_call_dispatcher
    import hall_call_dispatcher_pkg::*;
#(
    parameter int unsigned N_FLOORS    = N_FLOORS_DEF,
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input logic             clk,
    input logic             reset,
    hall_call_dispatcher_if.slave bus
);
    localparam int unsigned IW = idx_width(N_FLOORS);
    localparam int unsigned CW = cost_width(N_FLOORS);
    localparam logic [N_FLOORS-1:0] ONE = N_FLOORS'(1);

    if (TIMEOUT_CYC == 0) begin : g_timeout_check
        $error("TIMEOUT_CYC must be nonzero");
    end

    logic [N_FLOORS-1:0] pending, car0_calls, car1_calls;
    logic [0:0]          state;
    logic [IW-1:0]       sel, rr_ptr;
    logic [IW-1:0]       idx0, idx1;

    onehot_to_idx #(.N(N_FLOORS), .IW(IW)) u_idx0 (.onehot(bus.car0_floor), .idx(idx0));
    onehot_to_idx #(.N(N_FLOORS), .IW(IW)) u_idx1 (.onehot(bus.car1_floor), .idx(idx1));

    logic [N_FLOORS-1:0] stop0, stop1, stop_any, serve0, serve1, press;
    logic [N_FLOORS-1:0] timeout0, timeout1;

    always_comb begin
        stop0    = (bus.car0_state[1] == MV_IDLE) ? (ONE << idx0) : '0;
        stop1    = (bus.car1_state[1] == MV_IDLE) ? (ONE << idx1) : '0;
        stop_any = stop0 | stop1;
        serve0   = car0_calls & stop0;
        serve1   = car1_calls & stop1;
        // a stopped car at the floor blocks the press, so serve beats a same-cycle press
        press    = bus.external_buttons & ~(pending | car0_calls | car1_calls) & ~stop_any;
    end

    logic [IW-1:0] pick, cand;
    logic          pick_found;

    always_comb begin
        pick       = rr_ptr;
        cand       = '0;
        pick_found = 1'b0;
        for (int unsigned o = 0; o < N_FLOORS; o++) begin
            cand = IW'((32'(rr_ptr) + o) % N_FLOORS);
            if (!pick_found && pending[cand]) begin
                pick       = cand;
                pick_found = 1'b1;
            end
        end
    end

    logic [CW-1:0]       cost0, cost1;
    logic                behind0, behind1, pick_car1, commit_ok;
    logic [N_FLOORS-1:0] sel_mask, commit_clr, assign0, assign1;
`ifdef CALL_TIMEOUT_EN
    logic [N_FLOORS-1:0] excl_valid, excl_owner;
`endif

    always_comb begin
        behind0 = (bus.car0_state[1] == MV_MOVING) &&
                  (bus.car0_state[0] == DIR_UP ? (sel <= idx0) : (sel >= idx0));
        behind1 = (bus.car1_state[1] == MV_MOVING) &&
                  (bus.car1_state[0] == DIR_UP ? (sel <= idx1) : (sel >= idx1));
        cost0 = ((idx0 >= sel) ? CW'(idx0 - sel) : CW'(sel - idx0)) + (behind0 ? CW'(N_FLOORS) : '0);
        cost1 = ((idx1 >= sel) ? CW'(idx1 - sel) : CW'(sel - idx1)) + (behind1 ? CW'(N_FLOORS) : '0);
        pick_car1 = cost1 < cost0;
`ifdef CALL_TIMEOUT_EN
        if (excl_valid[sel]) pick_car1 = ~excl_owner[sel];
`endif
        sel_mask   = ONE << sel;
        commit_clr = (state == ST_COMMIT) ? sel_mask : '0;
        commit_ok  = (state == ST_COMMIT) && !stop_any[sel];
        assign0    = (commit_ok && !pick_car1) ? sel_mask : '0;
        assign1    = (commit_ok &&  pick_car1) ? sel_mask : '0;
    end

`ifdef CALL_TIMEOUT_EN
    localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
    logic [TW-1:0]       wait_cnt [N_FLOORS];
    logic [N_FLOORS-1:0] expired;

    always_comb begin
        for (int unsigned f = 0; f < N_FLOORS; f++) begin
            expired[f] = (wait_cnt[f] == TW'(TIMEOUT_CYC - 1));
        end
        timeout0 = car0_calls & ~serve0 & expired;
        timeout1 = car1_calls & ~serve1 & expired;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned f = 0; f < N_FLOORS; f++) wait_cnt[f] <= '0;
            excl_valid <= '0;
            excl_owner <= '0;
        end else begin
            for (int unsigned f = 0; f < N_FLOORS; f++) begin
                if (!(car0_calls[f] | car1_calls[f]) || serve0[f] || serve1[f] ||
                    timeout0[f] || timeout1[f])
                    wait_cnt[f] <= '0;
                else
                    wait_cnt[f] <= wait_cnt[f] + 1'b1;
            end
            excl_valid <= (excl_valid & ~commit_clr) | timeout0 | timeout1;
            excl_owner <= (excl_owner & ~(timeout0 | timeout1)) | timeout1;
        end
    end
`else
    always_comb begin
        timeout0 = '0;
        timeout1 = '0;
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending    <= '0;
            car0_calls <= '0;
            car1_calls <= '0;
            state      <= ST_IDLE;
            sel        <= '0;
            rr_ptr     <= '0;
        end else begin
            pending    <= (pending | press | timeout0 | timeout1) & ~commit_clr;
            car0_calls <= (car0_calls & ~serve0 & ~timeout0) | assign0;
            car1_calls <= (car1_calls & ~serve1 & ~timeout1) | assign1;
            if (state == ST_IDLE) begin
                if (|pending) begin
                    sel   <= pick;
                    state <= ST_COMMIT;
                end
            end else begin
                rr_ptr <= (sel == IW'(N_FLOORS - 1)) ? '0 : sel + 1'b1;
                state  <= ST_IDLE;
            end
        end
    end

    assign bus.car0_calls    = car0_calls;
    assign bus.car1_calls    = car1_calls;
    assign bus.hall_lamp     = pending | car0_calls | car1_calls;
    assign bus.dispatch_busy = (state != ST_IDLE);

endmodule
